// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, oversampling constants and baud divider helper.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH
  } uart_state_e;
`endif

  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; push while full is accepted only if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/loanio_uart_rx.sv
// rtl/loanio_uart_rx.sv - 16x oversampled UART receiver on an HPS loan-IO pin with output FIFO.
// Define UART_PARITY_EN for 8E1 framing with a parity_err pulse output.
module loanio_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int RX_PIN     = 49,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [66:0] loan_io_in,
  output logic [66:0] loan_io_out,
  output logic [66:0] loan_io_oe,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
`ifdef UART_PARITY_EN
  output logic        parity_err,
`endif
  output logic        overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e state, state_n;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          rx_meta, rx;
  logic [3:0]    tcnt, tcnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, pop, fe_n;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic          unused_pins;
`ifdef UART_PARITY_EN
  logic          par_bad, par_bad_n, pe_n;
`endif

  assign loan_io_out = '0;
  assign loan_io_oe  = '0;
  assign unused_pins = ^loan_io_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
      div_cnt <= '0;
    end else begin
      rx_meta <= loan_io_in[RX_PIN];
      rx      <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bidx      <= bidx_n;
      shreg     <= shreg_n;
      frame_err <= fe_n;
      overrun   <= push && fifo_full && !pop;
`ifdef UART_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= pe_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bidx_n  = bidx;
    shreg_n = shreg;
    push    = 1'b0;
    fe_n    = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_n = par_bad;
    pe_n      = 1'b0;
`endif
    case (state)
      ST_IDLE: if (!rx) begin
        state_n = ST_START;
        tcnt_n  = '0;
`ifdef UART_PARITY_EN
        par_bad_n = 1'b0;
`endif
      end
      ST_START: if (tick) begin
        if (tcnt == 4'(MID_SAMPLE)) begin
          if (rx) state_n = ST_IDLE;
          else begin
            state_n = ST_DATA;
            tcnt_n  = '0;
            bidx_n  = '0;
          end
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (tcnt == 4'(LAST_SAMPLE)) begin
          shreg_n = {rx, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
          tcnt_n  = '0;
`ifdef UART_PARITY_EN
          if (bidx == 3'd7) state_n = ST_PARITY;
`else
          if (bidx == 3'd7) state_n = ST_STOP;
`endif
        end else tcnt_n = tcnt + 4'd1;
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (tick) begin
        if (tcnt == 4'(LAST_SAMPLE)) begin
          pe_n      = (rx != ^shreg);
          par_bad_n = (rx != ^shreg);
          tcnt_n    = '0;
          state_n   = ST_STOP;
        end else tcnt_n = tcnt + 4'd1;
      end
`endif
      ST_STOP: if (tick) begin
        if (tcnt == 4'(LAST_SAMPLE)) begin
          if (rx) begin
`ifdef UART_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
            state_n = ST_IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = ST_WAIT_HIGH;
          end
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_WAIT_HIGH: if (rx) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;
  assign rx_data  = rx_valid ? fifo_head : '0;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_loanio_uart_rx.sv
// tb/tb_loanio_uart_rx.sv - directed vector bench for loanio_uart_rx at 16 clocks per bit.
module tb_loanio_uart_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line = 1'b1;
  logic        rx_ready = 1'b1;
  logic [66:0] lio_in;
  logic [66:0] lio_out, lio_oe;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  logic        pin_driven = 1'b0;
  logic [7:0]  rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         stop_cycles;
    logic       exp_v;
  } vec_t;

  vec_t vecs[6];

  assign lio_in = {{17{1'b1}}, line, {49{1'b1}}};

  loanio_uart_rx #(
    .CLK_HZ(1600000), .BAUD(100000), .RX_PIN(49), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .loan_io_in  (lio_in),
    .loan_io_out (lio_out),
    .loan_io_oe  (lio_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (lio_oe != '0 || lio_out != '0) pin_driven <= 1'b1;
    if (reset_n && rx_valid && rx_ready) rx_q.push_back(rx_data);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stop bit is sampled on the 155th edge after the start bit begins.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles,
                            input bit chk_lat, input logic exp_v, input bit pulse_ready);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    drive_bit(stop_v, 10);
    if (chk_lat) chk("pre_stop_valid", rx_valid, 0);
    if (pulse_ready) rx_ready = 1'b1;
    @(posedge clk); #1;
    if (pulse_ready) rx_ready = 1'b0;
    if (chk_lat) begin
      chk("lat_valid", rx_valid, exp_v);
      if (exp_v) chk("lat_data", rx_data, b);
    end
    repeat (stop_cycles - 11) @(posedge clk);
    #1;
    line = 1'b1;
  endtask

  initial begin
    int q0, f0, o0;
    vecs[0] = '{8'hA5, 1'b1, 16, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 40, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 16, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 16, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 16, 1'b1};
    vecs[5] = '{8'h55, 1'b1, 16, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    drive_bit(1'b1, 10);

    for (int v = 0; v < 6; v++) begin
      q0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt;
      send_frame(vecs[v].data, vecs[v].stop_v, vecs[v].stop_cycles, 1'b1, vecs[v].exp_v, 1'b0);
      drive_bit(1'b1, 6);
      chk("vec_bytes", rx_q.size() - q0, vecs[v].exp_v ? 1 : 0);
      if (vecs[v].exp_v) chk("vec_byte_val", rx_q[rx_q.size()-1], vecs[v].data);
      chk("vec_frame_err", fe_cnt - f0, vecs[v].exp_v ? 0 : 1);
      chk("vec_overrun", ov_cnt - o0, 0);
    end

    q0 = rx_q.size(); f0 = fe_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    chk("glitch_bytes", rx_q.size() - q0, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_frame_err", fe_cnt - f0, 0);
    send_frame(8'hC3, 1'b1, 16, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 4);

    rx_ready = 1'b0;
    q0 = rx_q.size(); o0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 16, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 4);
      if (i == 4) chk("ovr_none_at_4", ov_cnt - o0, 0);
    end
    chk("ovr_pulse", ov_cnt - o0, 1);
    chk("ovr_held_valid", rx_valid, 1);
    rx_ready = 1'b1;
    drive_bit(1'b1, 8);
    chk("ovr_read_count", rx_q.size() - q0, 4);
    for (int i = 0; i < 4; i++) chk("ovr_read_val", rx_q[q0+i], 32'(i+1));
    chk("ovr_drained", rx_valid, 0);

    rx_ready = 1'b0;
    q0 = rx_q.size(); o0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i*16), 1'b1, 16, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 4);
    end
    send_frame(8'h77, 1'b1, 16, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 4);
    chk("simul_no_overrun", ov_cnt - o0, 0);
    rx_ready = 1'b1;
    drive_bit(1'b1, 8);
    chk("simul_count", rx_q.size() - q0, 5);
    for (int i = 0; i < 4; i++) chk("simul_val", rx_q[q0+i], 32'((i+1)*16));
    chk("simul_last", rx_q[q0+4], 8'h77);

    q0 = rx_q.size(); f0 = fe_cnt;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 64 + 5);
    reset_n = 1'b0;
    drive_bit(1'b1, 3);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    reset_n = 1'b1;
    drive_bit(1'b1, 80);
    chk("midrst_no_byte", rx_q.size() - q0, 0);
    send_frame(8'h5A, 1'b1, 16, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 6);
    chk("midrst_next_count", rx_q.size() - q0, 1);
    chk("midrst_frame_err_cnt", fe_cnt - f0, 0);

    chk("pin_never_driven", pin_driven, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/loanio_uart_rx.md
Name: loanio_uart_rx

Overview:
- UART receiver on an HPS loan-IO pin; consumes h2f_loan_io_in from the HPS system and drives its h2f_loan_io_oe/h2f_loan_io_out buses.
- Pin 49 is loaned to the FPGA fabric as the UART RX line.
- Frames arriving bytes (8N1, or 8E1 with the option below) and buffers them in a small FIFO with a valid/ready output towards the receiver datapath.

Parameters:
- CLK_HZ, 50000000, fabric clock frequency.
- BAUD, 115200, line rate.
- RX_PIN, 49, loan-IO index used as RX (0..66).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  fabric clock (the same clock as the HPS loan-IO interface).
- reset_n  in  1  asynchronous active-low reset.
- loan_io_in  in  67  from HPS h2f_loan_io_in.
- loan_io_out  out  67  to HPS h2f_loan_io_out; constant 0.
- loan_io_oe  out  67  to HPS h2f_loan_io_oe; constant 0, so the RX pin is input-only.
- rx_data  out  8  head-of-FIFO byte.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while FIFO full.

Behaviour:
- Clock/reset: single clock domain. reset_n is asynchronous assert, synchronous deassert handled externally. Reset values: rx_valid=0, rx_data=0, frame_err=0, overrun=0, FIFO empty, FSM=IDLE, synchronizer flops=1 (line idle).
- Input sync: loan_io_in[RX_PIN] passes through a 2-FF synchronizer before any use.
- Tick generator: divider DIV = CLK_HZ/(BAUD*16), integer-truncated, minimum 1. The counter wraps 0..DIV-1 and emits a one-cycle tick at wrap, giving 16 ticks per bit. It runs freely; phase error is bounded by one tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A 4-bit tick counter and a 3-bit bit index.
  - IDLE: on a synchronized falling level (rx=0) go to START and clear the tick counter.
  - START: at tick count 7 (mid-bit), rx=1 means a false start and returns to IDLE. rx=0 clears the tick counter and goes to DATA.
  - DATA: at tick count 15, sample rx into the shift register LSB-first, then increment the bit index. After bit 7 go to STOP.
  - STOP: at tick count 15, rx=1 means a valid byte; push it to the FIFO and go to IDLE. rx=0 pulses frame_err, drops the byte and goes to WAIT_HIGH.
  - WAIT_HIGH: stay until rx=1, then go to IDLE (break condition does not generate bytes).
- FIFO: synchronous, with FIFO_DEPTH entries and show-ahead head.
  - rx_data is valid in the cycle rx_valid is high.
  - Latency from the stop-bit sample to rx_valid is 1 cycle.
- Full FIFO: a new byte is dropped, overrun pulses, and existing contents are unchanged.
- Simultaneous push and pop: allowed at any fill level, including full (pop frees a slot, push is accepted, no overrun) and empty (push then visible next cycle).
- Occupancy count: log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: FSM returns to IDLE, the FIFO empties and the partial byte is discarded.

Optional Feature:
- UART_PARITY_EN defined:
  - Adds state PARITY between DATA and STOP, sampled at tick 15; even parity over the 8 data bits.
  - On mismatch: output port parity_err pulses one cycle and the byte is dropped; the stop bit is still checked.
- UART_PARITY_EN undefined: 8N1 only; no parity_err port and no PARITY state.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum;
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15;
  - function computing DIV from CLK_HZ/BAUD.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), reused by other receiver stages.

Test Plan (CLK_HZ=1600000, BAUD=100000, so DIV=1 and 16 clocks per bit; FIFO_DEPTH=4):
- Byte 0xA5, 8N1, rx_ready=1 -> rx_valid pulses with rx_data=0xA5, 1 cycle after the stop-bit sample; frame_err=0, overrun=0; loan_io_oe and loan_io_out stay 0.
- Glitch low for 4 clocks on idle line -> no byte, FSM back in IDLE, rx_valid stays 0.
- Byte 0x3C with stop bit driven 0 for 40 clocks -> frame_err pulses once, no byte pushed. After the line returns high, byte 0x81 is received correctly.
- rx_ready=0, send 0x01..0x05 -> four bytes held and overrun pulses on the 5th. With rx_ready=1, reads return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- FIFO full and rx_ready=1 in the same cycle that byte 0x77 completes -> no overrun; 0x77 appears after the existing entries.
- reset_n asserted during data bit 4 of 0xFF -> all outputs at reset values, no byte delivered. The next frame, 0x5A, is received correctly.
